// File: rtl/ff_bank_shift.sv
// ff_bank_shift: parametrised register bank with hold, load, shift, rotate,
// toggle and arithmetic-shift modes. It has serial taps at both ends, a
// registered change flag and a combinational zero flag.
module ff_bank_shift #(
  parameter int              WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] SET_VALUE   = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             changed,
  output logic             zero
);

  // Operation encodings for the mode input.
  typedef enum logic [2:0] {
    MODE_HOLD   = 3'b000,
    MODE_LOAD   = 3'b001,
    MODE_SHL    = 3'b010,
    MODE_SHR    = 3'b011,
    MODE_ROTL   = 3'b100,
    MODE_ROTR   = 3'b101,
    MODE_TOGGLE = 3'b110,
    MODE_ASR    = 3'b111
  } bankMode_e;

  bankMode_e        modeSel;
  logic [WIDTH-1:0] bank_q;
  logic [WIDTH-1:0] bank_d;
  logic [WIDTH-1:0] modeResult;
  logic             changed_q;
  logic             changed_d;

  assign modeSel = bankMode_e'(mode);

  // Compute the value the selected mode would produce from the current bank.
  always_comb begin
    modeResult = bank_q;
    unique case (modeSel)
      MODE_HOLD:   modeResult = bank_q;
      MODE_LOAD:   modeResult = d;
      MODE_SHL:    modeResult = {bank_q[WIDTH-2:0], sin_r};
      MODE_SHR:    modeResult = {sin_l, bank_q[WIDTH-1:1]};
      MODE_ROTL:   modeResult = {bank_q[WIDTH-2:0], bank_q[WIDTH-1]};
      MODE_ROTR:   modeResult = {bank_q[0], bank_q[WIDTH-1:1]};
      MODE_TOGGLE: modeResult = bank_q ^ d;
      MODE_ASR:    modeResult = {bank_q[WIDTH-1], bank_q[WIDTH-1:1]};
      default:     modeResult = bank_q;
    endcase
  end

  // Set outranks the enable. Reset is handled in the register itself, so
  // here only set/en/mode decide the next bank value and whether it changes.
  always_comb begin
    bank_d    = bank_q;
    changed_d = 1'b0;
    if (set) begin
      bank_d = SET_VALUE;
    end else if (en) begin
      bank_d = modeResult;
    end
    changed_d = (bank_d != bank_q);
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q    <= RESET_VALUE;
      changed_q <= 1'b0;
    end else begin
      bank_q    <= bank_d;
      changed_q <= changed_d;
    end
  end

  assign q       = bank_q;
  assign changed = changed_q;
  assign sout_l  = bank_q[WIDTH-1];
  assign sout_r  = bank_q[0];
  assign zero    = (bank_q == '0);

endmodule
